// File: rtl/link_bert.sv
// Link bit-error-rate tester: sends LFSR payloads to an encoder and
// scores the words echoed back through a decoder.
module link_bert #(
  parameter int          N_PKT    = 8,
  parameter int          N_TRIALS = 256,
  parameter int          TIMEOUT  = 2000000,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] SEED     = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  output logic             start_ENC,
  input  logic             avail_ENC,
  output logic [N_PKT-1:0] data_ENC,
  input  logic [N_PKT-1:0] data_DEC,
  input  logic             avail_DEC,
  input  logic             error_DEC,
  output logic             read_DEC,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] dec_err_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] trial_cnt,
  output logic [N_PKT-1:0] last_rx,
  output logic [N_PKT-1:0] last_exp
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int PW = $clog2(N_PKT + 1);
  localparam int AW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [31:0]      POLY  = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RX,
    NEXT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic [CNT_W-1:0] derr_q, derr_d;
  logic [CNT_W-1:0] tout_q, tout_d;
  logic [CNT_W-1:0] berr_q, berr_d;
  logic [CNT_W-1:0] trial_q, trial_d;
  logic [N_PKT-1:0] rx_q, rx_d;
  logic [N_PKT-1:0] exp_q, exp_d;
  logic             rd_blk_q;
  logic             rd_ok;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PW-1:0] popcnt(
    input logic [N_PKT-1:0] v
  );
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N_PKT; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [PW-1:0]    b
  );
    logic [AW-1:0] s;
    s = AW'(a) + AW'(b);
    return (s > AW'(CMAX)) ? CMAX : s[CNT_W-1:0];
  endfunction

  // Read is blocked the cycle after any read and right after reset,
  // so read_DEC can never pulse on back-to-back cycles.
  assign rd_ok = avail_DEC && !rd_blk_q && !abort;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    timer_d   = timer_q;
    pass_d    = pass_q;
    mism_d    = mism_q;
    derr_d    = derr_q;
    tout_d    = tout_q;
    berr_d    = berr_q;
    trial_d   = trial_q;
    rx_d      = rx_q;
    exp_d     = exp_q;
    start_ENC = 1'b0;
    read_DEC  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        read_DEC = rd_ok;
        if (start && !abort) begin
          pass_d  = '0;
          mism_d  = '0;
          derr_d  = '0;
          tout_d  = '0;
          berr_d  = '0;
          trial_d = '0;
          timer_d = '0;
          lfsr_d  = SEED;
          state_d = SEND;
        end
      end
      SEND: begin
        read_DEC = rd_ok;
        if (avail_ENC && !abort) begin
          start_ENC = 1'b1;
          exp_d     = lfsr_q[N_PKT-1:0];
          timer_d   = '0;
          state_d   = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (!abort) begin
          if (avail_DEC && !rd_blk_q) begin
            read_DEC = 1'b1;
            rx_d     = data_DEC;
            state_d  = NEXT;
            if (error_DEC) begin
              derr_d = sat_inc(derr_q);
            end else if (data_DEC == exp_q) begin
              pass_d = sat_inc(pass_q);
            end else begin
              mism_d = sat_inc(mism_q);
              berr_d = sat_add(berr_q,
                               popcnt(data_DEC ^ exp_q));
            end
          end else if (timer_q == TLAST) begin
            tout_d  = sat_inc(tout_q);
            state_d = NEXT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      NEXT: begin
        read_DEC = rd_ok;
        if (!abort) begin
          lfsr_d  = {1'b0, lfsr_q[31:1]} ^
                    (lfsr_q[0] ? POLY : 32'h0);
          trial_d = sat_inc(trial_q);
          if (!continuous && int'(trial_d) == N_TRIALS) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      timer_q  <= '0;
      pass_q   <= '0;
      mism_q   <= '0;
      derr_q   <= '0;
      tout_q   <= '0;
      berr_q   <= '0;
      trial_q  <= '0;
      rx_q     <= '0;
      exp_q    <= '0;
      rd_blk_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      pass_q   <= pass_d;
      mism_q   <= mism_d;
      derr_q   <= derr_d;
      tout_q   <= tout_d;
      berr_q   <= berr_d;
      trial_q  <= trial_d;
      rx_q     <= rx_d;
      exp_q    <= exp_d;
      rd_blk_q <= read_DEC;
    end
  end

  // Outside SEND the encoder bus shows the last payload sent.
  assign data_ENC = (state_q == SEND) ?
                    lfsr_q[N_PKT-1:0] : exp_q;

  assign busy = (state_q == SEND) ||
                (state_q == WAIT_RX) ||
                (state_q == NEXT);
  assign done = (state_q == DONE);

  assign pass_cnt     = pass_q;
  assign mismatch_cnt = mism_q;
  assign dec_err_cnt  = derr_q;
  assign timeout_cnt  = tout_q;
  assign bit_err_cnt  = berr_q;
  assign trial_cnt    = trial_q;
  assign last_rx      = rx_q;
  assign last_exp     = exp_q;

endmodule

// File: tb/tb_link_bert.sv
// Bench for link_bert: loopback decoder model with per-trial latency,
// corruption and error flags; payloads checked against a reference LFSR.
module tb_link_bert;

  localparam int          NP   = 8;
  localparam int          NT   = 4;
  localparam int          TO   = 50;
  localparam int          CW   = 4;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, continuous;
  logic          start_ENC, avail_ENC;
  logic [NP-1:0] data_ENC, data_DEC;
  logic          avail_DEC, error_DEC, read_DEC;
  logic          busy, done;
  logic [CW-1:0] pass_cnt, mismatch_cnt, dec_err_cnt;
  logic [CW-1:0] timeout_cnt, bit_err_cnt, trial_cnt;
  logic [NP-1:0] last_rx, last_exp;

  always #5 clk = ~clk;

  link_bert #(
    .N_PKT(NP), .N_TRIALS(NT), .TIMEOUT(TO),
    .CNT_W(CW), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .continuous(continuous),
    .start_ENC(start_ENC), .avail_ENC(avail_ENC),
    .data_ENC(data_ENC), .data_DEC(data_DEC),
    .avail_DEC(avail_DEC), .error_DEC(error_DEC),
    .read_DEC(read_DEC), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .mismatch_cnt(mismatch_cnt),
    .dec_err_cnt(dec_err_cnt), .timeout_cnt(timeout_cnt),
    .bit_err_cnt(bit_err_cnt), .trial_cnt(trial_cnt),
    .last_rx(last_rx), .last_exp(last_exp)
  );

  typedef struct {
    int          due;
    logic [NP-1:0] d;
    logic        e;
  } echo_t;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            n_start = 0;
  int            st_cyc = 0;
  logic          prev_rd = 1'b0;
  logic          prev_st = 1'b0;
  logic [CW-1:0] prev_to = '0;
  logic          hold = 1'b0;
  logic [NP-1:0] exp_q[$];
  echo_t         eq[$];
  int            lat_a[64];
  logic [NP-1:0] mask_a[64];
  logic          err_a[64];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  task automatic push_exp(input int n);
    logic [31:0] s;
    s = SEED;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(s[NP-1:0]);
      s = lstep(s);
    end
  endtask

  task automatic set_plan(input int lat);
    for (int i = 0; i < 64; i++) begin
      lat_a[i]  = lat;
      mask_a[i] = '0;
      err_a[i]  = 1'b0;
    end
  endtask

  task automatic clr_model();
    eq.delete();
    hold      = 1'b0;
    avail_DEC = 1'b0;
  endtask

  // Sample the cycle's outputs, react as the link would, then advance.
  task automatic tick();
    logic [NP-1:0] e;
    echo_t         w;
    #1;
    if (start_ENC) begin
      chk("st_b2b", {31'd0, prev_st}, 0);
      if (exp_q.size() == 0) begin
        chk("extra_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data_ENC", {24'd0, data_ENC}, {24'd0, e});
      end
      if (n_start < 64 && lat_a[n_start] != 0) begin
        w.due = cyc + lat_a[n_start];
        w.d   = data_ENC ^ mask_a[n_start];
        w.e   = err_a[n_start];
        eq.push_back(w);
      end
      n_start++;
      st_cyc = cyc;
    end
    if (read_DEC) begin
      chk("rd_b2b", {31'd0, prev_rd}, 0);
      hold = 1'b0;
    end
    // counter changes one sample after the edge that counts it
    if (timeout_cnt > prev_to) begin
      chk("to_lat", cyc - st_cyc, TO + 1);
    end
    prev_to = timeout_cnt;
    prev_st = start_ENC;
    prev_rd = read_DEC;
    @(negedge clk);
    cyc++;
    if (!hold && eq.size() > 0 && eq[0].due <= cyc) begin
      w         = eq.pop_front();
      hold      = 1'b1;
      data_DEC  = w.d;
      error_DEC = w.e;
    end
    avail_DEC = hold;
  endtask

  task automatic wait_done(input string r, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk({r, "_done"}, {31'd0, done}, 1);
    chk({r, "_sb"}, exp_q.size(), 0);
  endtask

  task automatic run(input string r);
    push_exp(NT);
    n_start = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(r, 3000);
  endtask

  task automatic cnts(input string r, input int p, input int m,
                      input int d, input int t, input int b,
                      input int tr);
    chk({r, "_pass"}, {28'd0, pass_cnt}, p);
    chk({r, "_mism"}, {28'd0, mismatch_cnt}, m);
    chk({r, "_derr"}, {28'd0, dec_err_cnt}, d);
    chk({r, "_tout"}, {28'd0, timeout_cnt}, t);
    chk({r, "_berr"}, {28'd0, bit_err_cnt}, b);
    chk({r, "_trial"}, {28'd0, trial_cnt}, tr);
  endtask

  task automatic zero_chk(input string r);
    #1;
    chk({r, "_busy"}, {31'd0, busy}, 0);
    chk({r, "_done0"}, {31'd0, done}, 0);
    chk({r, "_stenc"}, {31'd0, start_ENC}, 0);
    chk({r, "_rd"}, {31'd0, read_DEC}, 0);
    chk({r, "_denc"}, {24'd0, data_ENC}, 0);
    chk({r, "_lrx"}, {24'd0, last_rx}, 0);
    chk({r, "_lexp"}, {24'd0, last_exp}, 0);
    cnts(r, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    continuous = 1'b0;
    avail_ENC  = 1'b1;
    data_DEC   = '0;
    error_DEC  = 1'b0;
    avail_DEC  = 1'b0;
    set_plan(40);
    @(negedge clk);
    repeat (3) tick();
    zero_chk("rst");
    rst_n = 1'b1;
    repeat (3) tick();

    // stale decoder word in IDLE is drained, never scored
    hold      = 1'b1;
    data_DEC  = 8'h55;
    error_DEC = 1'b0;
    avail_DEC = 1'b1;
    #1;
    chk("flush_rd", {31'd0, read_DEC}, 1);
    repeat (4) tick();
    chk("flush_held", {31'd0, hold}, 0);
    chk("flush_busy", {31'd0, busy}, 0);
    cnts("flush", 0, 0, 0, 0, 0, 0);

    // clean loopback
    set_plan(40);
    run("A");
    cnts("A", 4, 0, 0, 0, 0, 4);
    chk("A_nstart", n_start, 4);
    push_exp(NT);
    chk("A_lexp", {24'd0, last_exp}, {24'd0, exp_q[NT-1]});
    chk("A_lrx", {24'd0, last_rx}, {24'd0, exp_q[NT-1]});
    repeat (10) tick();
    chk("A_hold", {31'd0, done}, 1);

    // second trial comes back with bits 0 and 3 flipped
    set_plan(40);
    mask_a[1] = 8'h09;
    run("B");
    cnts("B", 3, 1, 0, 0, 2, 4);

    // echo on the last timer count, no echo, one cycle late, normal
    set_plan(40);
    lat_a[0] = TO;
    lat_a[1] = 0;
    lat_a[2] = TO + 1;
    run("C");
    cnts("C", 2, 0, 0, 2, 0, 4);

    // decoder flags a correct word as corrupt
    set_plan(40);
    err_a[2] = 1'b1;
    run("D");
    cnts("D", 3, 0, 1, 0, 0, 4);

    // continuous run saturates, stalled SEND never times out
    set_plan(5);
    continuous = 1'b1;
    push_exp(64);
    n_start = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (n_start < 21 && k < 3000) begin
      tick();
      k++;
    end
    chk("E_starts", {31'd0, n_start >= 21}, 1);
    avail_ENC = 1'b0;
    repeat (TO + 20) tick();
    chk("E_busy", {31'd0, busy}, 1);
    chk("E_done", {31'd0, done}, 0);
    cnts("E", 15, 0, 0, 0, 0, 15);
    abort     = 1'b1;
    avail_ENC = 1'b1;
    #1;
    chk("E_ab_st", {31'd0, start_ENC}, 0);
    tick();
    abort      = 1'b0;
    continuous = 1'b0;
    #1;
    chk("E_ab_busy", {31'd0, busy}, 0);
    chk("E_ab_done", {31'd0, done}, 0);
    cnts("E_ab", 15, 0, 0, 0, 0, 15);
    repeat (10) tick();
    exp_q.delete();

    // reset in the middle of a wait
    set_plan(40);
    push_exp(NT);
    n_start = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (n_start < 3 && k < 3000) begin
      tick();
      k++;
    end
    repeat (5) tick();
    chk("F_pre", {28'd0, pass_cnt}, 2);
    chk("F_prebusy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    clr_model();
    zero_chk("F");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    set_plan(40);
    run("G");
    cnts("G", 4, 0, 0, 0, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
